// File: rtl/wb_result_sel.sv
// ============================================================================
// Module   : wb_result_sel
// Brief    : Registered writeback result selector with HI/LO ownership and
//            MFHI/MFLO stall on outstanding MULTU/DIVU operations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_result_sel #(
    parameter int WIDTH           = 32,
    parameter int PEND_W          = 2,
    parameter bit ZERO_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        signal,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic [WIDTH-1:0]  shifter_out,
    input  logic              mdu_start,
    input  logic              hilo_wr,
    input  logic [WIDTH-1:0]  hi_in,
    input  logic [WIDTH-1:0]  lo_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  data_out,
    output logic              out_err,
    output logic [PEND_W-1:0] pending
);

    localparam logic [5:0] c_ADD   = 6'b100000;
    localparam logic [5:0] c_SUB   = 6'b100010;
    localparam logic [5:0] c_AND   = 6'b100100;
    localparam logic [5:0] c_OR    = 6'b100101;
    localparam logic [5:0] c_SLT   = 6'b101010;
    localparam logic [5:0] c_SLL   = 6'b000000;
    localparam logic [5:0] c_SRL   = 6'b000010;
    localparam logic [5:0] c_MFHI  = 6'b010000;
    localparam logic [5:0] c_MFLO  = 6'b010010;
    localparam logic [5:0] c_MULTU = 6'b011001;
    localparam logic [5:0] c_DIVU  = 6'b011011;

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        WAIT_HILO = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_wait_hi;
    logic               w_wait_hi_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   w_data_nxt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [PEND_W-1:0]  r_pend;
    logic [PEND_W-1:0]  w_pend_nxt;

    logic               w_is_alu;
    logic               w_is_shift;
    logic               w_is_mf;
    logic               w_mf_hi;
    logic               w_is_md;
    logic               w_out_free;
    logic               w_pend_zero;
    logic               w_pend_max;
    logic               w_hilo_ok;
    logic               w_accept;
    logic               w_inc;
    logic               w_dec;
    logic [WIDTH-1:0]   w_hi_fwd;
    logic [WIDTH-1:0]   w_lo_fwd;
    logic               w_unused;

    // mdu_start is kept on the port list for compatibility only.
    assign w_unused = mdu_start;

    assign w_is_alu   = (signal == c_ADD) || (signal == c_SUB) || (signal == c_AND) ||
                        (signal == c_OR)  || (signal == c_SLT);
    assign w_is_shift = (signal == c_SLL) || (signal == c_SRL);
    assign w_is_mf    = (signal == c_MFHI) || (signal == c_MFLO);
    assign w_mf_hi    = (signal == c_MFHI);
    assign w_is_md    = (signal == c_MULTU) || (signal == c_DIVU);

    assign w_out_free  = !r_valid || out_ready;
    assign w_pend_zero = (r_pend == '0);
    assign w_pend_max  = &r_pend;
    // HI/LO is current now, either already settled or landing this very cycle.
    assign w_hilo_ok   = w_pend_zero || ((r_pend == PEND_W'(1)) && hilo_wr);
    assign w_hi_fwd    = hilo_wr ? hi_in : r_hi;
    assign w_lo_fwd    = hilo_wr ? lo_in : r_lo;

    assign in_ready = (r_state == RUN) && (w_is_md ? !w_pend_max : w_out_free);
    assign w_accept = in_valid && in_ready;

    assign w_inc      = w_accept && w_is_md;
    assign w_dec      = hilo_wr && !w_pend_zero;
    assign w_pend_nxt = r_pend + PEND_W'(w_inc) - PEND_W'(w_dec);

    always_comb begin
        w_state_nxt   = r_state;
        w_wait_hi_nxt = r_wait_hi;
        w_valid_nxt   = r_valid && !out_ready;
        w_data_nxt    = r_data;
        w_err_nxt     = r_err;
        case (r_state)
            RUN: begin
                if (w_accept) begin
                    if (w_is_alu) begin
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = alu_out;
                        w_err_nxt   = 1'b0;
                    end else if (w_is_shift) begin
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = shifter_out;
                        w_err_nxt   = 1'b0;
                    end else if (w_is_mf) begin
                        if (w_hilo_ok) begin
                            w_valid_nxt = 1'b1;
                            w_data_nxt  = w_mf_hi ? w_hi_fwd : w_lo_fwd;
                            w_err_nxt   = 1'b0;
                        end else begin
                            w_state_nxt   = WAIT_HILO;
                            w_wait_hi_nxt = w_mf_hi;
                        end
                    end else if (!w_is_md && ZERO_ON_ILLEGAL) begin
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = '0;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            WAIT_HILO: begin
                if (w_out_free && w_hilo_ok) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = r_wait_hi ? w_hi_fwd : w_lo_fwd;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_wait_hi <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_err     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wait_hi <= w_wait_hi_nxt;
            r_valid   <= w_valid_nxt;
            r_data    <= w_data_nxt;
            r_err     <= w_err_nxt;
            r_pend    <= w_pend_nxt;
            if (hilo_wr) begin
                r_hi <= hi_in;
                r_lo <= lo_in;
            end
        end
    end

    assign out_valid = r_valid;
    assign data_out  = r_data;
    assign out_err   = r_err;
    assign pending   = r_pend;

endmodule

`default_nettype wire
